if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage feeding the decode stage.
- Owns the PC, drives a variable-latency instruction-memory request/acknowledge interface, and presents {valid, instruction, PC+4} to decode through its own output register.
- Honours the hazard freeze from the hazard unit and branch redirects from execute.
- Uses a one-entry buffer so a fetch that completes during a freeze is not lost.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- freeze  in  1  hazard stall; hold the output register.
- branch_taken  in  1  redirect request from execute.
- branch_addr  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; word aligned.
- imem_rdata  in  32  fetched word; valid when imem_ack=1.
- imem_ack  in  1  fetch complete; may assert in the same cycle imem_req rises.
- if_valid  out  1  output holds a live instruction.
- if_instruction  out  32  fetched instruction.
- if_pc  out  32  address of if_instruction + 4.

Behaviour:
- Reset is asynchronous and active-low: rst=0 immediately forces the following, independent of clk, including mid-fetch.
  - state=IDLE, pc=RESET_PC.
  - if_valid=0, if_instruction=0, if_pc=0.
  - buffer empty, imem_req=0.
- An outstanding memory access killed by reset is simply abandoned. The memory must tolerate this.
- States:
  - IDLE: no request; go to RUN next cycle.
  - RUN: imem_req=1, imem_addr=pc.
  - SQUASH: imem_req=1, imem_addr=sq_addr; this request's data will be discarded.
  - STALL: imem_req=0; buffer full.
- imem_addr stays constant while imem_req=1 and imem_ack=0.
- Priority at each edge: branch_taken > ack capture > freeze hold.
- RUN, ack=1, freeze=0, no branch:
  - if_instruction<=imem_rdata, if_pc<=pc+4, if_valid<=1.
  - pc<=pc+4; stay in RUN.
  - Zero-wait memory gives 1 instruction/cycle.
- RUN, ack=0, freeze=0: if_valid<=0 (bubble); the other output fields are don't-care but held.
- freeze=1: if_valid, if_instruction and if_pc hold.
  - In RUN with ack=1: word goes to buffer with pc+4, pc<=pc+4, state goes to STALL.
  - In RUN with ack=0: stay in RUN.
- STALL, freeze=0:
  - Buffer moves to the output register with if_valid<=1.
  - Buffer clears; state goes to RUN, so the next request is issued the following cycle.
- STALL, freeze=1: hold everything.
- branch_taken=1, any state except IDLE:
  - pc<=branch_addr; if_valid<=0 regardless of freeze; buffer cleared.
  - From RUN with ack=0: sq_addr<=pc, go to SQUASH.
  - From RUN with ack=1: data discarded, stay in RUN.
  - From STALL: go to RUN.
  - From SQUASH: stay in SQUASH; sq_addr unchanged.
- SQUASH with ack=1: data dropped, nothing captured, pc unchanged, go to RUN.
- branch_taken in IDLE: pc<=branch_addr only.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- branch_addr[1:0] is ignored and forced to 00.
- No combinational path from freeze or branch_taken to imem_req or imem_addr. Both are functions of registered state only.

Test Plan:
- Reset release, zero-wait memory (ack tied to req, rdata=addr|32'hE000_0000) -> first valid 2 cycles after rst rises.
  - if_pc sequence 4, 8, 12, ...; instructions E000_0000, E000_0004, ...; if_valid continuously 1.
- Memory with 2-cycle ack latency -> imem_addr stable during each wait; if_valid pulses 1 every 2 cycles with a bubble between; pc increments only on ack.
- freeze=1 for 3 cycles starting when the output holds the word at addr 8, while ack for addr 12 arrives -> output holds addr 8's word and if_pc=12.
  - imem_req drops; when freeze falls, the word from addr 12 appears with if_pc=16; the next request is addr 16.
- branch_taken=1 (branch_addr=32'h100) while the request for addr 20 is outstanding with 3-cycle latency -> if_valid=0 next cycle.
  - imem_addr stays 20 until ack; that data is never output; the next request is 32'h100; the first valid output has if_pc=32'h104.
- branch_taken and freeze both high in the same cycle with the buffer full -> buffer discarded, if_valid=0, the next fetch is branch_addr.
- rst asserted mid-wait -> all outputs reach reset values without a clock edge; pc restarts at RESET_PC; pc wrap from 32'hFFFF_FFFC gives 32'h0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with variable-latency imem handshake, one-entry freeze buffer and branch squash
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic        if_valid,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc
);
   typedef enum logic [1:0] {IDLE, RUN, SQUASH, STALL} state_e;
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, sq_addr_q, sq_addr_d;
   logic [31:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;
   logic [31:0] out_instr_q, out_instr_d, out_pc_q, out_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] pc_inc, br_tgt;
   assign pc_inc         = pc_q + 32'd4;
   assign br_tgt         = branch_addr & 32'hFFFF_FFFC;
   assign imem_req       = (state_q == RUN) || (state_q == SQUASH);
   assign imem_addr      = (state_q == SQUASH) ? sq_addr_q : pc_q;
   assign if_valid       = out_valid_q;
   assign if_instruction = out_instr_q;
   assign if_pc          = out_pc_q;
   // next state: branch beats ack capture, ack capture beats freeze hold; buffer is full exactly in STALL
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      sq_addr_d   = sq_addr_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      if (state_q == IDLE) begin
         state_d = RUN;
         pc_d    = branch_taken ? br_tgt : pc_q;
      end else if (branch_taken) begin
         pc_d        = br_tgt;
         out_valid_d = 1'b0;
         state_d     = ((state_q == RUN && !imem_ack) || state_q == SQUASH) ? SQUASH : RUN;
         sq_addr_d   = (state_q == RUN && !imem_ack) ? pc_q : sq_addr_q;
      end else if (state_q == RUN) begin
         if (imem_ack && freeze) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_inc;
            pc_d        = pc_inc;
            state_d     = STALL;
         end else if (imem_ack) begin
            out_instr_d = imem_rdata;
            out_pc_d    = pc_inc;
            out_valid_d = 1'b1;
            pc_d        = pc_inc;
         end else if (!freeze) begin
            out_valid_d = 1'b0;
         end
      end else if (state_q == STALL) begin
         if (!freeze) begin
            out_instr_d = buf_instr_q;
            out_pc_d    = buf_pc_q;
            out_valid_d = 1'b1;
            state_d     = RUN;
         end
      end else begin
         state_d = imem_ack ? RUN : SQUASH;
      end
   end
   // state and datapath registers; reset abandons any outstanding access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         sq_addr_q   <= 32'd0;
         buf_instr_q <= 32'd0;
         buf_pc_q    <= 32'd0;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'd0;
         out_pc_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         sq_addr_q   <= sq_addr_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus randomized run checked against an instruction-stream model
module tb_if_stage;
   logic        clk = 1'b0, rst = 1'b1, freeze = 1'b0, branch_taken = 1'b0;
   logic [31:0] branch_addr = 32'd0;
   logic        imem_req, imem_ack, if_valid;
   logic [31:0] imem_addr, imem_rdata, if_instruction, if_pc;
   int          n_assert = 0, n_fail = 0, lat_cfg = 0, cnt, lat, deliveries;
   logic [31:0] exp_pc, p_addr, p_pc, p_instr, ba;
   logic        p_req, p_ack, p_valid, f, b;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hE000_0000;
   endfunction

   function automatic int pick();
      return (lat_cfg < 0) ? int'($urandom_range(3)) : lat_cfg;
   endfunction

   assign imem_rdata = mem(imem_addr);
   assign imem_ack   = imem_req && (cnt >= lat);

   // memory model: acknowledges each access after 'lat' wait cycles
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 0;
         lat <= pick();
      end else if (imem_req && imem_ack) begin
         cnt <= 0;
         lat <= pick();
      end else if (imem_req) begin
         cnt <= cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int l);
      lat_cfg = l;
      freeze = 1'b0;
      branch_taken = 1'b0;
      #2 rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      // reset values appear before any clock edge
      #2 rst = 1'b0;
      #1;
      chk("rst_valid", if_valid, 0);
      chk("rst_instr", if_instruction, 0);
      chk("rst_pc", if_pc, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      tick();
      rst = 1'b1;
      // zero-wait memory: first valid two cycles after release, then one per cycle
      tick();
      chk("zw_req", imem_req, 1);
      chk("zw_addr0", imem_addr, 0);
      chk("zw_bubble", if_valid, 0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk("zw_valid", if_valid, 1);
         chk("zw_pc", if_pc, 32'(4 * i));
         chk("zw_instr", if_instruction, mem(32'(4 * (i - 1))));
      end
      // two-cycle latency: valid every other cycle, address held while waiting
      do_reset(1);
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("lat2_valid", if_valid, (k >= 3 && k % 2 == 1));
         chk("lat2_addr", imem_addr, 32'(4 * ((k - 1) / 2)));
         if (k >= 3 && k % 2 == 1) chk("lat2_pc", if_pc, 32'(4 * ((k - 1) / 2)));
      end
      // freeze while addr 12 completes: word parked, released when freeze drops
      do_reset(0);
      repeat (4) tick();
      chk("frz_pre_pc", if_pc, 12);
      chk("frz_pre_addr", imem_addr, 12);
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_valid", if_valid, 1);
         chk("frz_pc", if_pc, 12);
         chk("frz_instr", if_instruction, mem(32'd8));
         chk("frz_req", imem_req, 0);
      end
      freeze = 1'b0;
      tick();
      chk("unfrz_valid", if_valid, 1);
      chk("unfrz_pc", if_pc, 16);
      chk("unfrz_instr", if_instruction, mem(32'd12));
      chk("unfrz_req", imem_req, 1);
      chk("unfrz_addr", imem_addr, 16);
      // branch and freeze together with buffer full
      do_reset(0);
      repeat (4) tick();
      freeze = 1'b1;
      tick();
      chk("bf_req", imem_req, 0);
      branch_taken = 1'b1;
      branch_addr = 32'h200;
      tick();
      branch_taken = 1'b0;
      freeze = 1'b0;
      chk("bf_valid", if_valid, 0);
      chk("bf_req2", imem_req, 1);
      chk("bf_addr", imem_addr, 32'h200);
      tick();
      chk("bf_out_valid", if_valid, 1);
      chk("bf_out_pc", if_pc, 32'h204);
      chk("bf_out_instr", if_instruction, mem(32'h200));
      // branch during a three-cycle access to addr 20
      do_reset(2);
      repeat (16) tick();
      chk("br_pre_addr", imem_addr, 20);
      chk("br_pre_pc", if_pc, 20);
      branch_taken = 1'b1;
      branch_addr = 32'h100;
      tick();
      branch_taken = 1'b0;
      chk("br_valid", if_valid, 0);
      chk("br_addr_hold", imem_addr, 20);
      tick();
      chk("br_addr_hold2", imem_addr, 20);
      chk("br_valid2", if_valid, 0);
      tick();
      chk("br_target", imem_addr, 32'h100);
      chk("br_valid3", if_valid, 0);
      tick();
      tick();
      chk("br_valid4", if_valid, 0);
      tick();
      chk("br_out_valid", if_valid, 1);
      chk("br_out_pc", if_pc, 32'h104);
      chk("br_out_instr", if_instruction, mem(32'h100));
      // asynchronous reset in the middle of a wait
      do_reset(3);
      repeat (6) tick();
      chk("mid_pc", if_pc, 4);
      chk("mid_req", imem_req, 1);
      chk("mid_addr", imem_addr, 4);
      lat_cfg = 0;
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", if_valid, 0);
      chk("ar_instr", if_instruction, 0);
      chk("ar_pc", if_pc, 0);
      chk("ar_req", imem_req, 0);
      chk("ar_addr", imem_addr, 0);
      tick();
      rst = 1'b1;
      // branch in IDLE to unaligned top address, then pc wraps to zero
      branch_taken = 1'b1;
      branch_addr = 32'hFFFF_FFFF;
      tick();
      branch_taken = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_valid0", if_valid, 0);
      tick();
      chk("wrap_valid", if_valid, 1);
      chk("wrap_pc", if_pc, 0);
      chk("wrap_instr", if_instruction, mem(32'hFFFF_FFFC));
      chk("wrap_next", imem_addr, 0);
      // randomized run against the fetched-stream model
      do_reset(-1);
      exp_pc = 32'd0;
      deliveries = 0;
      for (int i = 0; i < 3000; i++) begin
         p_req = imem_req;
         p_addr = imem_addr;
         p_valid = if_valid;
         p_pc = if_pc;
         p_instr = if_instruction;
         f = ($urandom_range(9) < 3);
         b = ($urandom_range(19) == 0);
         ba = $urandom;
         freeze = f;
         branch_taken = b;
         branch_addr = ba;
         #1;
         chk("comb_req", imem_req, p_req);
         chk("comb_addr", imem_addr, p_addr);
         p_ack = imem_ack;
         tick();
         chk("align", {30'd0, imem_addr[1:0]}, 0);
         if (p_req && !p_ack) begin
            chk("hold_req", imem_req, 1);
            chk("hold_addr", imem_addr, p_addr);
         end
         if (b) begin
            chk("rnd_br_valid", if_valid, 0);
            exp_pc = ba & 32'hFFFF_FFFC;
         end else if (f) begin
            chk("rnd_frz_valid", if_valid, p_valid);
            chk("rnd_frz_pc", if_pc, p_pc);
            chk("rnd_frz_instr", if_instruction, p_instr);
         end else if (if_valid) begin
            chk("rnd_pc", if_pc, exp_pc + 32'd4);
            chk("rnd_instr", if_instruction, mem(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
         end
      end
      chk("rnd_progress", deliveries > 200, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
